// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared cpu_ram_if types: ram state encoding and word type
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - WORDS x word_t storage, synchronous write port, combinational read port
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  word_t         wdata,
  input  logic [AW-1:0] ridx,
  output word_t         rdata
);

  // Contents are deliberately left unreset; callers only enable we for in-range indices.
  word_t mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - cpu_ram_if memory responder with programmable access latency
// Optional RAM_ALIGN_CHECK_EN: misaligned requests report ERROR instead of mapping to the word.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int LAT   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] memaddr,
  input  logic [31:0] memstore,
  input  logic        memREN,
  input  logic        memWEN,
  output logic [31:0] ramload,
  output ramstate_t   ramstate
);

  localparam int            AW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int            CW       = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LAT > 0) ? CW'(LAT - 1) : '0;
  localparam logic [29:0]   WORDS_W  = 30'(WORDS);

  logic          active_q, active_d;
  logic [31:0]   last_addr_q, last_addr_d;
  logic          last_wen_q, last_wen_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req;
  logic          match;
  logic          misaligned;
  logic          out_of_range;
  logic          wr_en;
  logic [AW-1:0] idx;
  word_t         rdata;

  assign idx          = memaddr[AW+1:2];
  assign req          = memREN || memWEN;
  assign match        = active_q && (memaddr == last_addr_q) && (memWEN == last_wen_q);
  assign out_of_range = memaddr[31:2] >= WORDS_W;

`ifdef RAM_ALIGN_CHECK_EN
  assign misaligned = memaddr[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    ramstate = BUSY;
    if (RST || !req) begin
      ramstate = FREE;
    end else if (memREN && memWEN) begin
      ramstate = ERROR;
    end else if (misaligned) begin
      ramstate = ERROR;
    end else if (out_of_range) begin
      ramstate = ERROR;
    end else if ((LAT == 0) || (match && (cnt_q == '0))) begin
      ramstate = ACCESS;
    end
  end

  // The write lands on the edge closing an ACCESS cycle, so a held request rewrites the same data.
  assign wr_en   = (ramstate == ACCESS) && memWEN;
  assign ramload = ((ramstate == ACCESS) && memREN) ? rdata : 32'h0;

  always_comb begin
    active_d    = active_q;
    last_addr_d = last_addr_q;
    last_wen_d  = last_wen_q;
    cnt_d       = cnt_q;
    if ((ramstate == FREE) || (ramstate == ERROR)) begin
      active_d = 1'b0;
    end else if (!match) begin
      active_d    = 1'b1;
      last_addr_d = memaddr;
      last_wen_d  = memWEN;
      cnt_d       = CNT_INIT;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
    last_addr_q <= last_addr_d;
    last_wen_q  <= last_wen_d;
  end

  ram_array #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_ram_array (
    .clk   (CLK),
    .we    (wr_en),
    .widx  (idx),
    .wdata (memstore),
    .ridx  (idx),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - self-checking bench for ram_responder at LAT 2, 3 and 0
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int WORDS = 1024;
  localparam int LATS [3] = '{2, 3, 0};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic [31:0] load  [3];
  logic        ren   [3];
  logic        wen   [3];
  ramstate_t   st    [3];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: word store per instance plus how long the current request has been served.
  logic [31:0] mem_m      [3][WORDS];
  bit          written    [3][WORDS];
  bit          prev_valid [3];
  logic [31:0] prev_addr  [3];
  logic        prev_wen   [3];
  int          age        [3];
  ramstate_t   exp_st     [3];
  logic [31:0] exp_ld     [3];
  bit          exp_kn     [3];

  always #5 CLK = ~CLK;

  ram_responder #(.WORDS(WORDS), .LAT(2)) u_lat2 (
    .CLK(CLK), .RST(RST), .memaddr(addr[0]), .memstore(store[0]), .memREN(ren[0]),
    .memWEN(wen[0]), .ramload(load[0]), .ramstate(st[0]));
  ram_responder #(.WORDS(WORDS), .LAT(3)) u_lat3 (
    .CLK(CLK), .RST(RST), .memaddr(addr[1]), .memstore(store[1]), .memREN(ren[1]),
    .memWEN(wen[1]), .ramload(load[1]), .ramstate(st[1]));
  ram_responder #(.WORDS(WORDS), .LAT(0)) u_lat0 (
    .CLK(CLK), .RST(RST), .memaddr(addr[2]), .memstore(store[2]), .memREN(ren[2]),
    .memWEN(wen[2]), .ramload(load[2]), .ramstate(st[2]));

  function automatic int served(int k);
    if (prev_valid[k] && addr[k] == prev_addr[k] && wen[k] == prev_wen[k]) return age[k];
    return 0;
  endfunction

  function automatic ramstate_t model_state(int k);
    if (RST) return FREE;
    if (!ren[k] && !wen[k]) return FREE;
    if (ren[k] && wen[k]) return ERROR;
`ifdef RAM_ALIGN_CHECK_EN
    if (addr[k][1:0] != 2'b00) return ERROR;
`endif
    if ((addr[k] >> 2) >= 32'(WORDS)) return ERROR;
    if (served(k) >= LATS[k]) return ACCESS;
    return BUSY;
  endfunction

  task automatic set_req(int k, bit r, bit w, logic [31:0] a, logic [31:0] d);
    ren[k]   = r;
    wen[k]   = w;
    addr[k]  = a;
    store[k] = d;
  endtask

  task automatic eval();
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      exp_st[k] = model_state(k);
      exp_ld[k] = 32'h0;
      exp_kn[k] = 1'b1;
      if (exp_st[k] == ACCESS && ren[k]) begin
        int idx = int'(addr[k] >> 2);
        exp_ld[k] = mem_m[k][idx];
        exp_kn[k] = written[k][idx];
      end
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 3; k++) begin
      ramstate_t es = model_state(k);
      if (es == ACCESS && wen[k]) begin
        int idx = int'(addr[k] >> 2);
        mem_m[k][idx]   = store[k];
        written[k][idx] = 1'b1;
      end
      if (es == BUSY || es == ACCESS) begin
        if (served(k) > 0) begin
          age[k]++;
        end else begin
          prev_valid[k] = 1'b1;
          prev_addr[k]  = addr[k];
          prev_wen[k]   = wen[k];
          age[k]        = 1;
        end
      end else begin
        prev_valid[k] = 1'b0;
        age[k]        = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int k = 0; k < 3; k++) set_req(k, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 2; c++) begin
      eval();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (st[k] !== FREE || load[k] !== 32'h0) begin
          miscompares++;
          $display("FAIL reset dut%0d cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                   k, c, st[k], load[k], FREE, 32'h0);
        end
      end
      commit();
    end
    RST = 1'b0;
    for (int k = 0; k < 3; k++) set_req(k, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_read();
    ramstate_t   seq [4] = '{BUSY, BUSY, ACCESS, FREE};
    logic [31:0] lds [4] = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
    set_req(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      eval();
      vectors++;
      if (st[0] !== exp_st[0] || load[0] !== exp_ld[0]) begin
        miscompares++;
        $display("FAIL read_preload cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                 c, st[0], load[0], exp_st[0], exp_ld[0]);
      end
      commit();
    end
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      eval();
      vectors++;
      if (st[0] !== seq[c] || load[0] !== lds[c] || st[0] !== exp_st[0] || load[0] !== exp_ld[0]) begin
        miscompares++;
        $display("FAIL read cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                 c, st[0], load[0], seq[c], lds[c]);
      end
      commit();
    end
  endtask

  task automatic test_write();
    ramstate_t   seq [6] = '{BUSY, BUSY, ACCESS, BUSY, BUSY, ACCESS};
    logic [31:0] lds [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678};
    for (int c = 0; c < 6; c++) begin
      if (c == 0) set_req(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
      if (c == 3) set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
      eval();
      vectors++;
      if (st[0] !== seq[c] || load[0] !== lds[c] || st[0] !== exp_st[0] || load[0] !== exp_ld[0]) begin
        miscompares++;
        $display("FAIL write cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                 c, st[0], load[0], seq[c], lds[c]);
      end
      commit();
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_restart();
    logic [31:0] d [4];
    ramstate_t   es;
    logic [31:0] el;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    for (int c = 0; c < 8; c++) begin
      set_req(1, 1'b0, 1'b1, (c < 4) ? 32'h40 : 32'h44, (c < 4) ? d[0] : d[1]);
      eval();
      vectors++;
      if (st[1] !== exp_st[1] || load[1] !== exp_ld[1]) begin
        miscompares++;
        $display("FAIL restart_preload cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                 c, st[1], load[1], exp_st[1], exp_ld[1]);
      end
      commit();
    end
    for (int c = 0; c < 14; c++) begin
      if (c == 0)       set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
      else if (c < 5)   set_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
      else if (c == 5)  set_req(1, 1'b0, 1'b1, 32'h40, d[2]);
      else if (c < 10)  set_req(1, 1'b0, 1'b1, 32'h44, d[3]);
      else              set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
      es = (c == 4 || c == 9 || c == 13) ? ACCESS : BUSY;
      el = (c == 4) ? d[1] : (c == 13) ? d[0] : 32'h0;
      eval();
      vectors++;
      if (st[1] !== es || load[1] !== el || st[1] !== exp_st[1] || load[1] !== exp_ld[1]) begin
        miscompares++;
        $display("FAIL restart cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                 c, st[1], load[1], es, el);
      end
      commit();
    end
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_errors();
    ramstate_t   seq [7];
    logic [31:0] lds [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
`ifdef RAM_ALIGN_CHECK_EN
    seq = '{ERROR, ERROR, ERROR, ERROR, ERROR, ERROR, FREE};
    lds[5] = 32'h0;
`else
    seq = '{ERROR, ERROR, ERROR, BUSY, BUSY, ACCESS, FREE};
`endif
    for (int c = 0; c < 7; c++) begin
      case (c)
        0:       set_req(0, 1'b1, 1'b1, 32'h10, 32'h0);
        1:       set_req(0, 1'b1, 1'b0, 32'(4 * WORDS), 32'h0);
        2:       set_req(0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF);
        6:       set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        default: set_req(0, 1'b1, 1'b0, 32'h11, 32'h0);
      endcase
      eval();
      vectors++;
      if (st[0] !== seq[c] || load[0] !== lds[c] || st[0] !== exp_st[0] || load[0] !== exp_ld[0]) begin
        miscompares++;
        $display("FAIL errors cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                 c, st[0], load[0], seq[c], lds[c]);
      end
      commit();
    end
  endtask

  task automatic test_lat0();
    logic [31:0] d0 = $urandom;
    logic [31:0] d1 = $urandom;
    ramstate_t   seq [5] = '{ACCESS, ACCESS, ACCESS, ACCESS, FREE};
    logic [31:0] lds [5];
    lds = '{32'h0, d0, 32'h0, d1, 32'h0};
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       set_req(2, 1'b0, 1'b1, 32'h8, d0);
        2:       set_req(2, 1'b0, 1'b1, 32'h8, d1);
        4:       set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        default: set_req(2, 1'b1, 1'b0, 32'h8, 32'h0);
      endcase
      eval();
      vectors++;
      if (st[2] !== seq[c] || load[2] !== lds[c] || st[2] !== exp_st[2] || load[2] !== exp_ld[2]) begin
        miscompares++;
        $display("FAIL lat0 cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                 c, st[2], load[2], seq[c], lds[c]);
      end
      commit();
    end
  endtask

  task automatic test_reset_busy();
    ramstate_t   seq [5] = '{BUSY, FREE, BUSY, BUSY, ACCESS};
    logic [31:0] lds [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D};
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 5; c++) begin
      RST = (c == 1);
      eval();
      vectors++;
      if (st[0] !== seq[c] || load[0] !== lds[c] || st[0] !== exp_st[0] || load[0] !== exp_ld[0]) begin
        miscompares++;
        $display("FAIL reset_busy cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                 c, st[0], load[0], seq[c], lds[c]);
      end
      commit();
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      RST = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          int          kind = $urandom_range(0, 15);
          logic [31:0] a    = 32'($urandom_range(0, 15)) << 2;
          if (kind == 3) a = 32'(WORDS + $urandom_range(0, 255)) << 2;
          if (kind == 4) a = a + 32'($urandom_range(1, 3));
          set_req(k, (kind == 2) || (kind >= 3 && kind <= 9), (kind == 2) || (kind >= 10),
                  a, $urandom);
          if (kind < 2) set_req(k, 1'b0, 1'b0, a, 32'h0);
        end
      end
      eval();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (st[k] !== exp_st[k] || (exp_kn[k] && load[k] !== exp_ld[k])) begin
          miscompares++;
          $display("FAIL random dut%0d cyc%0d: state=%0d load=%h, expected state=%0d load=%h",
                   k, c, st[k], load[k], exp_st[k], exp_ld[k]);
        end
      end
      commit();
    end
    RST = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      set_req(k, 1'b0, 1'b0, 32'h0, 32'h0);
      prev_valid[k] = 1'b0;
      prev_addr[k]  = 32'h0;
      prev_wen[k]   = 1'b0;
      age[k]        = 0;
    end
    test_reset();
    test_read();
    test_write();
    test_restart();
    test_errors();
    test_lat0();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
